p405s_timertsrtcr: RTL and testbench



---
 rtl/p405s_timertsrtcr_pkg.sv | 27 ++
 rtl/p405s_timertsrtcr_tsr_bit.sv | 21 ++
 rtl/p405s_timertsrtcr.sv | 140 ++++++++++++++
 tb/tb_p405s_timertsrtcr.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/p405s_timertsrtcr_pkg.sv
// Shared timer definitions: SPR numbers, TCR/TSR field positions and WRC encodings.
// Field positions use big-endian numbering: bit 0 is the MSB of the 32-bit SPR.
package p405s_timertsrtcr_pkg;

    localparam logic [0:9] TCR_SPRN = 10'h3DA;  // 986
    localparam logic [0:9] TSR_SPRN = 10'h3D8;  // 984

    // TCR field start bits (two-bit fields occupy start and start+1)
    localparam int TCR_WP  = 0;
    localparam int TCR_WRC = 2;
    localparam int TCR_WIE = 4;
    localparam int TCR_FP  = 6;
    localparam int TCR_FIE = 8;

    // TSR field start bits
    localparam int TSR_ENW = 0;
    localparam int TSR_WIS = 1;
    localparam int TSR_WRS = 2;
    localparam int TSR_FIS = 5;

    // Watchdog reset control encodings
    localparam logic [0:1] WRC_NONE = 2'b00;
    localparam logic [0:1] WRC_CORE = 2'b01;
    localparam logic [0:1] WRC_CHIP = 2'b10;
    localparam logic [0:1] WRC_SYS  = 2'b11;

endpackage

// File: rtl/p405s_timertsrtcr_tsr_bit.sv
// Single write-one-to-clear status bit; a hardware set in the same cycle as a
// software clear wins, so an event is never lost to a racing clear.
module p405s_timertsrtcr_tsr_bit (
    input  logic clk,
    input  logic rst,
    input  logic hw_set,
    input  logic sw_clr,
    output logic q
);

    // Set has priority over clear; reset clears.
    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (hw_set)
            q <= 1'b1;
        else if (sw_clr)
            q <= 1'b0;
    end

endmodule

// File: rtl/p405s_timertsrtcr.sv
// Timer Control Register and Timer Status Register for the 405 timer unit.
// Serves mtspr/mfspr, feeds the watchdog/FIT equations stage and raises the
// watchdog and FIT interrupt requests.
module p405s_timertsrtcr
    import p405s_timertsrtcr_pkg::*;
(
    input  logic        CB,
    input  logic        resetCore,
    input  logic        sprWrEn,
    input  logic        sprRdEn,
    input  logic [0:9]  sprNum,
    input  logic [0:31] sprWrData,
    output logic [0:31] sprRdData,
    output logic        sprRdVld,
    input  logic        wdPulse,
    input  logic        hwSetWdIntrp,
    input  logic        hwSetWdRst,
    input  logic        hwSetFitStatus,
    output logic        enableNxtWdTic,
    output logic        wdIntrpBit,
    output logic [0:1]  wdRstType,
    output logic [0:1]  wdTapSel,
    output logic [0:1]  fitTapSel,
    output logic        TIM_wdIntrp,
    output logic        TIM_fitIntrp
);

    logic [0:1]  wp, wrc, fp, wrs;
    logic        wie, fie;
    logic        enw, wis, fis;
    logic        tcr_wr, tsr_wr, tcr_sel, tsr_sel;
    logic [0:31] tcr_val, tsr_val, rd_val;
    logic        unused_wr_bits;

    assign tcr_sel = (sprNum == TCR_SPRN);
    assign tsr_sel = (sprNum == TSR_SPRN);
    assign tcr_wr  = sprWrEn && tcr_sel;
    assign tsr_wr  = sprWrEn && tsr_sel;

    // Bits 9..31 are reserved in both registers
    assign unused_wr_bits = ^sprWrData[9:31];

    // TCR: plain fields load on write; WRC only ever accumulates ones until reset
    always_ff @(posedge CB) begin
        if (resetCore) begin
            wp  <= 2'b00;
            wrc <= WRC_NONE;
            wie <= 1'b0;
            fp  <= 2'b00;
            fie <= 1'b0;
        end else if (tcr_wr) begin
            wp  <= sprWrData[TCR_WP +: 2];
            wrc <= wrc | sprWrData[TCR_WRC +: 2];
            wie <= sprWrData[TCR_WIE];
            fp  <= sprWrData[TCR_FP +: 2];
            fie <= sprWrData[TCR_FIE];
        end
    end

    // TSR single-bit fields. ENW only sets from 0, so gating by ~enw keeps a
    // tic on an already-enabled watchdog from overriding a software clear.
    p405s_timertsrtcr_tsr_bit u_enw (
        .clk    (CB),
        .rst    (resetCore),
        .hw_set (wdPulse && !enw),
        .sw_clr (tsr_wr && sprWrData[TSR_ENW]),
        .q      (enw)
    );

    p405s_timertsrtcr_tsr_bit u_wis (
        .clk    (CB),
        .rst    (resetCore),
        .hw_set (hwSetWdIntrp),
        .sw_clr (tsr_wr && sprWrData[TSR_WIS]),
        .q      (wis)
    );

    p405s_timertsrtcr_tsr_bit u_fis (
        .clk    (CB),
        .rst    (resetCore),
        .hw_set (hwSetFitStatus),
        .sw_clr (tsr_wr && sprWrData[TSR_FIS]),
        .q      (fis)
    );

    // WRS captures the pre-write WRC on a watchdog reset; otherwise per-bit W1C
    always_ff @(posedge CB) begin
        if (resetCore)
            wrs <= WRC_NONE;
        else if (hwSetWdRst && (wrc != WRC_NONE))
            wrs <= wrc;
        else if (tsr_wr)
            wrs <= wrs & ~sprWrData[TSR_WRS +: 2];
    end

    // Assemble architected register images from the current (pre-update) state
    always_comb begin
        tcr_val = '0;
        tcr_val[TCR_WP +: 2]  = wp;
        tcr_val[TCR_WRC +: 2] = wrc;
        tcr_val[TCR_WIE]      = wie;
        tcr_val[TCR_FP +: 2]  = fp;
        tcr_val[TCR_FIE]      = fie;

        tsr_val = '0;
        tsr_val[TSR_ENW]      = enw;
        tsr_val[TSR_WIS]      = wis;
        tsr_val[TSR_WRS +: 2] = wrs;
        tsr_val[TSR_FIS]      = fis;
    end

    // Read mux; unknown SPR numbers return zero
    always_comb begin
        rd_val = '0;
        if (tcr_sel)
            rd_val = tcr_val;
        else if (tsr_sel)
            rd_val = tsr_val;
    end

    // Registered read return, one cycle after the strobe
    always_ff @(posedge CB) begin
        if (resetCore) begin
            sprRdData <= '0;
            sprRdVld  <= 1'b0;
        end else begin
            sprRdData <= sprRdEn ? rd_val : 32'h0;
            sprRdVld  <= sprRdEn;
        end
    end

    assign enableNxtWdTic = enw;
    assign wdIntrpBit     = wis;
    assign wdRstType      = wrc;
    assign wdTapSel       = wp;
    assign fitTapSel      = fp;
    assign TIM_wdIntrp    = wis && wie;
    assign TIM_fitIntrp   = fis && fie;

endmodule

// File: tb/tb_p405s_timertsrtcr.sv
// Bench for the TCR/TSR block: expected mfspr data is queued when a read is
// issued and compared when sprRdVld returns; status outputs checked directly.
module tb_p405s_timertsrtcr;

    logic        CB = 1'b0;
    logic        resetCore;
    logic        sprWrEn, sprRdEn;
    logic [0:9]  sprNum;
    logic [0:31] sprWrData;
    logic [0:31] sprRdData;
    logic        sprRdVld;
    logic        wdPulse, hwSetWdIntrp, hwSetWdRst, hwSetFitStatus;
    logic        enableNxtWdTic, wdIntrpBit, TIM_wdIntrp, TIM_fitIntrp;
    logic [0:1]  wdRstType, wdTapSel, fitTapSel;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    localparam logic [0:9] TCR = 10'h3DA;
    localparam logic [0:9] TSR = 10'h3D8;
    localparam logic [0:9] BAD = 10'h3D9;

    p405s_timertsrtcr dut (
        .CB             (CB),
        .resetCore      (resetCore),
        .sprWrEn        (sprWrEn),
        .sprRdEn        (sprRdEn),
        .sprNum         (sprNum),
        .sprWrData      (sprWrData),
        .sprRdData      (sprRdData),
        .sprRdVld       (sprRdVld),
        .wdPulse        (wdPulse),
        .hwSetWdIntrp   (hwSetWdIntrp),
        .hwSetWdRst     (hwSetWdRst),
        .hwSetFitStatus (hwSetFitStatus),
        .enableNxtWdTic (enableNxtWdTic),
        .wdIntrpBit     (wdIntrpBit),
        .wdRstType      (wdRstType),
        .wdTapSel       (wdTapSel),
        .fitTapSel      (fitTapSel),
        .TIM_wdIntrp    (TIM_wdIntrp),
        .TIM_fitIntrp   (TIM_fitIntrp)
    );

    always #5 CB = ~CB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each returned read against the oldest expectation
    always @(posedge CB) begin
        #2;
        if (sprRdVld) begin
            if (exp_q.size() == 0)
                chk("rd_unexpected", 32'(sprRdVld), 32'h0);
            else
                chk("rd_data", sprRdData, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge CB);
        #1;
    endtask

    // One SPR access; rd queues the expected pre-update value
    task automatic spr(input bit wr, input bit rd, input logic [0:9] num,
                       input logic [31:0] data, input logic [31:0] exp);
        sprWrEn   = wr;
        sprRdEn   = rd;
        sprNum    = num;
        sprWrData = data;
        if (rd) exp_q.push_back(exp);
        step();
        sprWrEn = 1'b0;
        sprRdEn = 1'b0;
    endtask

    task automatic wr(input logic [0:9] num, input logic [31:0] data);
        spr(1'b1, 1'b0, num, data, 32'h0);
    endtask

    task automatic rd(input logic [0:9] num, input logic [31:0] exp);
        spr(1'b0, 1'b1, num, 32'h0, exp);
    endtask

    task automatic do_reset();
        resetCore = 1'b1;
        step();
        step();
        resetCore = 1'b0;
    endtask

    initial begin
        resetCore = 1'b1; sprWrEn = 0; sprRdEn = 0; sprNum = '0; sprWrData = '0;
        wdPulse = 0; hwSetWdIntrp = 0; hwSetWdRst = 0; hwSetFitStatus = 0;

        // Reset state
        do_reset();
        chk("rst_outs", 32'({enableNxtWdTic, wdIntrpBit, wdRstType, wdTapSel, fitTapSel,
                             TIM_wdIntrp, TIM_fitIntrp, sprRdVld}), 32'h0);
        chk("rst_rddata", sprRdData, 32'h0);
        rd(TSR, 32'h0);
        rd(TCR, 32'h0);

        // TCR load and WRC stickiness
        wr(TCR, 32'hE880_0000);
        chk("tcr_wp", 32'(wdTapSel), 32'h3);
        chk("tcr_wrc", 32'(wdRstType), 32'h2);
        chk("wdint_no_wis", 32'(TIM_wdIntrp), 32'h0);
        rd(TCR, 32'hE880_0000);
        wr(TCR, 32'h0000_0000);
        chk("wrc_sticky", 32'({wdRstType, wdTapSel}), 32'h8);
        rd(TCR, 32'h2000_0000);

        // Watchdog sequence 00 -> 10 -> 11, then clear WIS
        wr(TCR, 32'h0B80_0000);
        chk("fp", 32'(fitTapSel), 32'h3);
        rd(TCR, 32'h2B80_0000);
        wdPulse = 1; step(); wdPulse = 0;
        chk("enw_set", 32'({enableNxtWdTic, wdIntrpBit}), 32'h2);
        hwSetWdIntrp = 1; step(); hwSetWdIntrp = 0;
        chk("wis_set", 32'({enableNxtWdTic, wdIntrpBit, TIM_wdIntrp}), 32'h7);
        rd(TSR, 32'hC000_0000);
        wr(TSR, 32'h4000_0000);
        chk("wis_clr", 32'({enableNxtWdTic, wdIntrpBit, TIM_wdIntrp}), 32'h4);

        // FIS: hardware set beats a coincident clear
        hwSetFitStatus = 1;
        wr(TSR, 32'h0400_0000);
        hwSetFitStatus = 0;
        chk("fis_hw_wins", 32'(TIM_fitIntrp), 32'h1);
        rd(TSR, 32'h8400_0000);
        wr(TSR, 32'h0400_0000);
        chk("fis_clr", 32'(TIM_fitIntrp), 32'h0);

        // WRC=11 then watchdog reset captures into WRS
        wr(TCR, 32'h3000_0000);
        chk("wrc_or", 32'(wdRstType), 32'h3);
        hwSetWdRst = 1; step(); hwSetWdRst = 0;
        rd(TSR, 32'hB000_0000);
        // Concurrent read+clear of WRS returns the old value
        spr(1'b1, 1'b1, TSR, 32'h3000_0000, 32'hB000_0000);
        rd(TSR, 32'h8000_0000);
        // WRC write coincident with reset event: WRS takes pre-write WRC
        do_reset();
        wr(TCR, 32'h1000_0000);
        hwSetWdRst = 1;
        wr(TCR, 32'h2000_0000);
        hwSetWdRst = 0;
        rd(TSR, 32'h1000_0000);
        rd(TCR, 32'h3000_0000);

        // resetCore clears everything
        do_reset();
        rd(TSR, 32'h0);
        rd(TCR, 32'h0);
        chk("rst2_outs", 32'({enableNxtWdTic, wdIntrpBit, wdRstType, wdTapSel, fitTapSel}), 32'h0);

        // Unknown SPR: reads zero, writes ignored
        wr(TCR, 32'hC000_0000);
        rd(BAD, 32'h0);
        wr(BAD, 32'hFFFF_FFFF);
        rd(TCR, 32'hC000_0000);
        rd(TSR, 32'h0);

        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
